regfile_mp: RTL



---
 rtl/regfile_mp_pkg.sv | 7 +
 rtl/regfile_mp_sb.sv | 48 ++++
 rtl/regfile_mp.sv | 64 ++++++
 3 files changed

// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults and types for the multi-port register file
package regfile_mp_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int ADDR_DEF = $clog2(NREG_DEF);
    typedef logic [ADDR_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: pending-write scoreboard with registered population count
module regfile_mp_sb import regfile_mp_pkg::*; #(
    parameter int NREG   = NREG_DEF,
    parameter int AW     = $clog2(NREG),
    parameter int NUM_WR = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_WR-1:0]            wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]    wr_addr_i,
    input  logic                         sb_set_en_i,
    input  logic [AW-1:0]                sb_set_addr_i,
    input  logic                         sb_flush_i,
    output logic [NREG-1:0]              busy_o,
    output logic [AW:0]                  busy_cnt_o
);
    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;

    // flush beats set, set beats a same-address write clear; x0 never pending
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        if (sb_flush_i) begin
            busy_d = '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++)
                if (wr_en_i[w] && wr_addr_i[w] != '0) busy_d[wr_addr_i[w]] = 1'b0;
            if (sb_set_en_i && sb_set_addr_i != '0) busy_d[sb_set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
        for (int r = 1; r < NREG; r++) cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end

    // busy vector and its count advance together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write bypass and scoreboard
module regfile_mp import regfile_mp_pkg::*; #(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int AW     = $clog2(NREG),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter bit BYPASS = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD-1:0][AW-1:0]     rd_addr_i,
    output logic [NUM_RD-1:0][XLEN-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]             rd_busy_o,
    input  logic [NUM_WR-1:0]             wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]     wr_addr_i,
    input  logic [NUM_WR-1:0][XLEN-1:0]   wr_data_i,
    input  logic                          sb_set_en_i,
    input  logic [AW-1:0]                 sb_set_addr_i,
    input  logic                          sb_flush_i,
    output logic                          busy_any_o,
    output logic [AW:0]                   busy_cnt_o
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy;

    regfile_mp_sb #(.NREG(NREG), .AW(AW), .NUM_WR(NUM_WR)) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .sb_set_en_i   (sb_set_en_i),
        .sb_set_addr_i (sb_set_addr_i),
        .sb_flush_i    (sb_flush_i),
        .busy_o        (busy),
        .busy_cnt_o    (busy_cnt_o)
    );

    // array writes; later ports overwrite earlier ones on an address clash, x0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++)
                if (wr_en_i[w] && wr_addr_i[w] != '0) regs_q[wr_addr_i[w]] <= wr_data_i[w];
        end
    end

    // array mux first, then the bypass mux where the highest-index hitting port wins
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data_o[i] = (rd_addr_i[i] == '0) ? '0 : regs_q[rd_addr_i[i]];
            rd_busy_o[i] = busy[rd_addr_i[i]];
            if (BYPASS)
                for (int w = 0; w < NUM_WR; w++)
                    if (wr_en_i[w] && wr_addr_i[w] != '0 && wr_addr_i[w] == rd_addr_i[i]) begin
                        rd_data_o[i] = wr_data_i[w];
                        rd_busy_o[i] = 1'b0;
                    end
        end
    end

    assign busy_any_o = (busy_cnt_o != '0);
endmodule
